axi_debug_master_v2: RTL and testbench

- Second-generation JTAG-driven AXI4-Lite debug master.
- A debug register bus (from the debugport block) programs address, data and byte strobes, then launches single AXI4-Lite reads and writes.
- Adds over v1:
  - parametrised address width and increment stride;
  - concurrent AW/W issue;
  - byte strobes;
  - read auto-increment;
  - BRESP/RRESP error capture;
  - a transaction timeout;
  - busy/overrun reporting.

---
 rtl/axi_debug_master_v2.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_axi_debug_master_v2.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_debug_master_v2.sv
// axi_debug_master_v2
// JTAG-driven AXI4-Lite debug master. A small debug register bus programs the
// target address, write data and byte strobes, then launches single AXI4-Lite
// reads or writes. Completion status, the sticky error and response flags, the
// timeout flag and the overrun flag are all readable through the same bus.
//
// Ports
//   m00_axi_aclk, m00_axi_areset : clock, synchronous active-high reset
//   dbg_wr, dbg_rd               : one-cycle write/read strobes (dbg_rd has no side effects)
//   dbg_addr, dbg_wdata          : register select and write data
//   dbg_rdata                    : combinational read data for dbg_addr
//   m00_axi_*                    : AXI4-Lite master channels (AW, W, B, AR, R)
module axi_debug_master_v2 #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          ADDR_STRIDE    = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] IDCODE         = 32'h41584932
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_areset,
    input  logic                  dbg_wr,
    input  logic                  dbg_rd,
    input  logic [2:0]            dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic [31:0]           dbg_rdata,
    output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [2:0]            m00_axi_awprot,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    output logic [31:0]           m00_axi_wdata,
    output logic [3:0]            m00_axi_wstrb,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]            m00_axi_arprot,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [31:0]           m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

    localparam logic [2:0] REG_SETADDR_READ  = 3'd1;
    localparam logic [2:0] REG_SETADDR       = 3'd2;
    localparam logic [2:0] REG_SETDATA_WRITE = 3'd3;
    localparam logic [2:0] REG_SETDATA_INC_W = 3'd4;
    localparam logic [2:0] REG_INCADDR_READ  = 3'd5;
    localparam logic [2:0] REG_SETCTRL       = 3'd6;
    localparam logic [2:0] REG_STATUS        = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   txn_addr_q, txn_addr_d;
    logic [31:0]             txn_data_q, txn_data_d;
    logic [3:0]              strb_q, strb_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [1:0]              resp_q, resp_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic busy;
    logic launch_rd, launch_wr;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic expired;
    logic unused_dbg_rd;

    assign unused_dbg_rd = dbg_rd;

    assign busy    = (state_q != S_IDLE);
    assign aw_hs   = awvalid_q & m00_axi_awready;
    assign w_hs    = wvalid_q  & m00_axi_wready;
    assign b_hs    = bready_q  & m00_axi_bvalid;
    assign ar_hs   = arvalid_q & m00_axi_arready;
    assign r_hs    = rready_q  & m00_axi_rvalid;
    assign expired = TO_EN && (cnt_q == CNT_LAST);

    assign m00_axi_awaddr  = txn_addr_q;
    assign m00_axi_araddr  = txn_addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_wdata   = txn_data_q;
    assign m00_axi_wstrb   = strb_q;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

    always_comb begin
        dbg_rdata = 32'hFFFF_FFFF;
        case (dbg_addr)
            3'd0:       dbg_rdata = IDCODE;
            3'd1:       dbg_rdata = txn_data_q;
            3'd2:       dbg_rdata = 32'(txn_addr_q);
            3'd3:       dbg_rdata = {28'b0, strb_q};
            REG_STATUS: dbg_rdata = {25'b0, overrun_q, timeout_q, resp_q, err_q, busy, done_q};
            default:    dbg_rdata = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        txn_addr_d = txn_addr_q;
        txn_data_d = txn_data_q;
        strb_d     = strb_q;
        done_d     = done_q;
        err_d      = err_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        cnt_d      = cnt_q;
        launch_rd  = 1'b0;
        launch_wr  = 1'b0;

        if (dbg_wr) begin
            if (busy) begin
                // Command dropped; only the flag-clear part of SETCTRL survives.
                overrun_d = 1'b1;
                if (dbg_addr == REG_SETCTRL && dbg_wdata[8]) begin
                    err_d     = 1'b0;
                    resp_d    = 2'b00;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                end
            end else begin
                case (dbg_addr)
                    REG_SETADDR_READ: begin
                        txn_addr_d = dbg_wdata[ADDR_WIDTH-1:0];
                        launch_rd  = 1'b1;
                    end
                    REG_SETADDR: txn_addr_d = dbg_wdata[ADDR_WIDTH-1:0];
                    REG_SETDATA_WRITE: begin
                        txn_data_d = dbg_wdata;
                        launch_wr  = 1'b1;
                    end
                    REG_SETDATA_INC_W: begin
                        txn_addr_d = txn_addr_q + STRIDE;
                        txn_data_d = dbg_wdata;
                        launch_wr  = 1'b1;
                    end
                    REG_INCADDR_READ: begin
                        txn_addr_d = txn_addr_q + STRIDE;
                        launch_rd  = 1'b1;
                    end
                    REG_SETCTRL: begin
                        strb_d = dbg_wdata[3:0];
                        if (dbg_wdata[8]) begin
                            err_d     = 1'b0;
                            resp_d    = 2'b00;
                            timeout_d = 1'b0;
                            overrun_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (launch_wr) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            done_d    = 1'b0;
            cnt_d     = '0;
        end
        if (launch_rd) begin
            state_d   = S_READ;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            done_d    = 1'b0;
            cnt_d     = '0;
        end

        case (state_q)
            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // A response arriving before both AW and W completed is accepted but flagged.
                if (b_hs) begin
                    resp_d    = m00_axi_bresp;
                    err_d     = err_d | (m00_axi_bresp != 2'b00)
                              | ~((aw_done_q | aw_hs) & (w_done_q | w_hs));
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else if (expired) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ar_hs) arvalid_d = 1'b0;
                if (r_hs) begin
                    txn_data_d = m00_axi_rdata;
                    resp_d     = m00_axi_rresp;
                    err_d      = err_d | (m00_axi_rresp != 2'b00);
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else if (expired) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q    <= S_IDLE;
            txn_addr_q <= '0;
            txn_data_q <= '0;
            strb_q     <= 4'hF;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            resp_q     <= 2'b00;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            txn_addr_q <= txn_addr_d;
            txn_data_q <= txn_data_d;
            strb_q     <= strb_d;
            done_q     <= done_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_debug_master_v2.sv
module tb_axi_debug_master_v2;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_wr = 1'b0, dbg_rd = 1'b0;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic [31:0] dbg_rdata;
    logic [31:0] awaddr, araddr, wdata, rdata = 32'd0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;

    axi_debug_master_v2 #(
        .ADDR_WIDTH(32), .ADDR_STRIDE(4), .TIMEOUT_CYCLES(TO), .IDCODE(32'h41584932)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of the programmer-visible state.
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    logic [1:0]  m_resp;
    logic        m_done, m_err, m_to, m_ovr;

    function automatic logic [31:0] m_status();
        return {25'b0, m_ovr, m_to, m_resp, m_err, 1'b0, m_done};
    endfunction

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_strb = 4'hF; m_resp = 0;
        m_done = 0; m_err = 0; m_to = 0; m_ovr = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [2:0] a, input logic [31:0] d);
        dbg_addr = a; dbg_wdata = d; dbg_wr = 1'b1;
        tick();
        dbg_wr = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        dbg_addr = a; dbg_rd = 1'b1;
        #1;
        check(tag, dbg_rdata, exp);
        dbg_rd = 1'b0;
    endtask

    // Issue a command from idle and apply its effect to the model.
    task automatic model_cmd(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd1, 3'd2: m_addr = d;
            3'd3: m_data = d;
            3'd4: begin m_addr = m_addr + 32'd4; m_data = d; end
            3'd5: m_addr = m_addr + 32'd4;
            3'd6: begin
                m_strb = d[3:0];
                if (d[8]) begin m_err = 0; m_resp = 0; m_to = 0; m_ovr = 0; end
            end
            default: ;
        endcase
        if (a == 3'd1 || a == 3'd3 || a == 3'd4 || a == 3'd5) m_done = 0;
        dbg_write(a, d);
    endtask

    task automatic do_write(input string tag, input logic [2:0] cmd, input logic [31:0] d,
                            input int awd, input int wd, input int bd, input logic [1:0] resp);
        int cyc, aw_cnt, w_cnt, bstart;
        logic fin;
        logic [31:0] ga, gd;
        logic [3:0] gs;
        cyc = 0; aw_cnt = 0; w_cnt = 0; fin = 0; ga = 'x; gd = 'x; gs = 'x;
        bstart = ((awd > wd) ? awd : wd) + 1 + bd;
        model_cmd(cmd, d);
        while (!fin && cyc < 40) begin
            awready = (cyc >= awd);
            wready  = (cyc >= wd);
            bvalid  = (cyc >= bstart);
            bresp   = resp;
            #1;
            if (awvalid && awready) begin aw_cnt++; ga = awaddr; end
            if (wvalid && wready) begin w_cnt++; gd = wdata; gs = wstrb; end
            if (bvalid && bready) fin = 1;
            tick();
            cyc++;
        end
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        m_resp = resp; m_err = m_err | (resp != 0); m_done = 1;
        check({tag, "/completed"}, 32'(fin), 32'd1);
        check({tag, "/aw_count"}, aw_cnt, 1);
        check({tag, "/w_count"}, w_cnt, 1);
        check({tag, "/awaddr"}, ga, m_addr);
        check({tag, "/wdata"}, gd, m_data);
        check({tag, "/wstrb"}, 32'(gs), 32'(m_strb));
        check({tag, "/idle_outputs"}, {29'b0, awvalid, wvalid, bready}, 32'd0);
        check_reg({tag, "/status"}, 3'd7, m_status());
    endtask

    task automatic do_read(input string tag, input logic [2:0] cmd, input logic [31:0] d,
                           input int ard, input int rd, input logic [31:0] rdat,
                           input logic [1:0] resp);
        int cyc, ar_cnt;
        logic fin;
        logic [31:0] ga;
        cyc = 0; ar_cnt = 0; fin = 0; ga = 'x;
        model_cmd(cmd, d);
        while (!fin && cyc < 40) begin
            arready = (cyc >= ard);
            rvalid  = (cyc >= ard + 1 + rd);
            rdata   = rdat;
            rresp   = resp;
            #1;
            if (arvalid && arready) begin ar_cnt++; ga = araddr; end
            if (rvalid && rready) fin = 1;
            tick();
            cyc++;
        end
        arready = 0; rvalid = 0; rresp = 0;
        m_data = rdat; m_resp = resp; m_err = m_err | (resp != 0); m_done = 1;
        check({tag, "/completed"}, 32'(fin), 32'd1);
        check({tag, "/ar_count"}, ar_cnt, 1);
        check({tag, "/araddr"}, ga, m_addr);
        check({tag, "/idle_outputs"}, {30'b0, arvalid, rready}, 32'd0);
        check_reg({tag, "/rdata_reg"}, 3'd1, m_data);
        check_reg({tag, "/status"}, 3'd7, m_status());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int arv_cnt;
        logic [2:0] op;

        // Reset
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_reg("reset/idcode", 3'd0, 32'h41584932);
        check_reg("reset/addr", 3'd2, 32'd0);
        check_reg("reset/strb", 3'd3, 32'hF);
        check_reg("reset/status", 3'd7, 32'd0);
        check_reg("reset/unmapped", 3'd5, 32'hFFFF_FFFF);
        check("reset/valids", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);

        // Basic write, AW and W accepted together
        model_cmd(3'd2, 32'h1000);
        do_write("wr_basic", 3'd3, 32'hCAFEF00D, 0, 0, 2, 2'b00);

        // W accepted three cycles before AW
        do_write("wr_w_first", 3'd3, 32'h0BADBEEF, 3, 0, 1, 2'b00);

        // Strobes and address wrap
        model_cmd(3'd6, 32'h3);
        check_reg("strb_reg", 3'd3, 32'h3);
        model_cmd(3'd2, 32'hFFFF_FFF8);
        do_write("wr_inc0", 3'd4, 32'h55, 0, 1, 0, 2'b00);
        do_write("wr_inc1", 3'd4, 32'h55, 1, 0, 0, 2'b00);
        do_write("wr_inc2", 3'd4, 32'h55, 2, 2, 1, 2'b00);
        check_reg("wrap/addr", 3'd2, 32'h4);

        // Read with SLVERR, then auto-increment read, then flag clear
        do_read("rd_slverr", 3'd1, 32'h2000, 1, 1, 32'h12345678, 2'b10);
        check_reg("rd_slverr/status_exact", 3'd7, 32'h15);
        do_read("rd_inc", 3'd5, 32'h0, 0, 0, 32'hA5A5_0001, 2'b00);
        check_reg("rd_inc/addr", 3'd2, 32'h2004);
        model_cmd(3'd6, 32'h103);
        check_reg("clear/status", 3'd7, m_status());

        // Timeout with an overrunning command mid-wait
        model_cmd(3'd1, 32'h3000);
        arv_cnt = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            #1;
            if (arvalid) arv_cnt++;
            if (cyc == 5) begin
                dbg_addr = 3'd2; dbg_wdata = 32'hDEAD; dbg_wr = 1'b1;
            end else begin
                dbg_wr = 1'b0;
            end
            tick();
        end
        dbg_wr = 1'b0;
        m_ovr = 1; m_to = 1; m_err = 1; m_done = 1;
        check("timeout/arvalid_cycles", arv_cnt, TO);
        check("timeout/outputs", {30'b0, arvalid, rready}, 32'd0);
        check_reg("timeout/status", 3'd7, m_status());
        check_reg("timeout/status_exact", 3'd7, 32'h65);
        check_reg("timeout/addr_kept", 3'd2, 32'h3000);
        model_cmd(3'd6, 32'h10F);
        check_reg("timeout/cleared", 3'd7, m_status());

        // Randomised transactions against the model
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                model_cmd(3'd6, {23'b0, 1'b0, 4'b0, 4'($urandom_range(0, 15))});
                check_reg($sformatf("rnd%0d/strb", i), 3'd3, 32'(m_strb));
            end
            op = 3'($urandom_range(0, 3));
            case (op)
                3'd0: do_read($sformatf("rnd%0d/rd", i), 3'd1, $urandom, $urandom_range(0, 4),
                              $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
                3'd1: do_write($sformatf("rnd%0d/wr", i), 3'd3, $urandom, $urandom_range(0, 4),
                               $urandom_range(0, 4), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
                3'd2: do_write($sformatf("rnd%0d/wrinc", i), 3'd4, $urandom, $urandom_range(0, 4),
                               $urandom_range(0, 4), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
                default: do_read($sformatf("rnd%0d/rdinc", i), 3'd5, 32'd0, $urandom_range(0, 4),
                                 $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
            endcase
            check_reg($sformatf("rnd%0d/addr", i), 3'd2, m_addr);
        end

        // Reset in the middle of a write
        model_cmd(3'd3, 32'h7777_0000);
        check("midreset/launched", {29'b0, awvalid, wvalid, bready}, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("midreset/outputs", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check_reg("midreset/data", 3'd1, m_data);
        check_reg("midreset/strb", 3'd3, 32'(m_strb));
        check_reg("midreset/status", 3'd7, m_status());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
